// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and constants for the instruction fetch stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  // Instruction fetch is word-granular; the low PC bits carry no meaning.
  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_hold_buf.sv
// ============================================================================
// Module : fetch_hold_buf
// Brief  : One-entry skid buffer for an instruction returned while decode stalls.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               load,
  input  logic               clear,
  input  logic [31:0]        pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               valid,
  output logic [31:0]        pc,
  output logic [INSTR_W-1:0] instr
);

  logic               valid_d, valid_q;
  logic [31:0]        pc_d, pc_q;
  logic [INSTR_W-1:0] instr_d, instr_q;

  // Clear wins so a redirect in the same cycle as a capture discards the data.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      valid_d = 1'b0;
      pc_d    = '0;
      instr_d = '0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      instr_d = instr_in;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module : fetch_stage
// Brief  : PC sequencing, I-memory handshake and F/D register; optional perf
//          counters enabled with macro FETCH_PERF_CNT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               stall_D,
  input  logic               flush_D,
  input  logic               redirect,
  input  logic [31:0]        redirect_PC,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [31:0]        PC_D,
  output logic [INSTR_W-1:0] Instr_D,
  output logic [31:0]        PC_plus4_D,
  output logic               valid_D,
  output logic               fetch_busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_miss_cycles
`endif
);

  localparam logic [31:0] RESET_PC_A = RESET_PC & ~32'h0000_0003;

  fetch_state_t       state_d, state_q;
  logic [31:0]        pc_d, pc_q;
  logic [31:0]        drop_addr_d, drop_addr_q;
  logic [31:0]        pc_fd_d, pc_fd_q;
  logic [INSTR_W-1:0] instr_fd_d, instr_fd_q;
  logic [31:0]        pc4_fd_d, pc4_fd_q;
  logic               valid_fd_d, valid_fd_q;
  logic               fd_load;
  logic               hb_load, hb_clear, hb_valid;
  logic [31:0]        hb_pc;
  logic [INSTR_W-1:0] hb_instr;
  logic [31:0]        pc_next;

  assign pc_next = pc_q + PC_STEP;

  fetch_hold_buf u_hold_buf (
    .CLK      (CLK),
    .RST      (RST),
    .load     (hb_load),
    .clear    (hb_clear),
    .pc_in    (pc_q),
    .instr_in (imem_rdata),
    .valid    (hb_valid),
    .pc       (hb_pc),
    .instr    (hb_instr)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    pc_fd_d     = pc_fd_q;
    instr_fd_d  = instr_fd_q;
    pc4_fd_d    = pc4_fd_q;
    valid_fd_d  = valid_fd_q;
    fd_load     = 1'b0;
    hb_load     = 1'b0;
    hb_clear    = 1'b0;

    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          if (stall_D) begin
            hb_load = 1'b1;
            state_d = HOLD;
          end else begin
            fd_load    = 1'b1;
            pc_fd_d    = pc_q;
            instr_fd_d = imem_rdata;
            pc4_fd_d   = pc_next;
            valid_fd_d = 1'b1;
            pc_d       = pc_next;
          end
        end
      end
      HOLD: begin
        if (!stall_D) begin
          fd_load    = 1'b1;
          pc_fd_d    = hb_pc;
          instr_fd_d = hb_instr;
          pc4_fd_d   = hb_pc + PC_STEP;
          valid_fd_d = hb_valid;
          pc_d       = pc_next;
          hb_clear   = 1'b1;
          state_d    = FETCH;
        end
      end
      DROP: begin
        if (imem_ready) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Nothing new reached decode and decode is free: insert a bubble.
    if (!fd_load && !stall_D) valid_fd_d = 1'b0;

    // Redirect discards everything in flight; an unanswered request must
    // still complete at its original address before the new target goes out.
    if (redirect) begin
      pc_d     = pc_align(redirect_PC);
      hb_load  = 1'b0;
      hb_clear = 1'b1;
      if (state_q != HOLD && !imem_ready) begin
        state_d     = DROP;
        drop_addr_d = (state_q == DROP) ? drop_addr_q : pc_q;
      end else begin
        state_d = FETCH;
      end
    end

    if (flush_D || redirect) begin
      pc_fd_d    = '0;
      instr_fd_d = '0;
      pc4_fd_d   = '0;
      valid_fd_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC_A;
      drop_addr_q <= '0;
      pc_fd_q     <= '0;
      instr_fd_q  <= '0;
      pc4_fd_q    <= '0;
      valid_fd_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      pc_fd_q     <= pc_fd_d;
      instr_fd_q  <= instr_fd_d;
      pc4_fd_q    <= pc4_fd_d;
      valid_fd_q  <= valid_fd_d;
    end
  end

  assign imem_req   = !RST && (state_q != HOLD);
  assign imem_addr  = (state_q == DROP) ? drop_addr_q : pc_q;
  assign fetch_busy = !RST && (state_q != HOLD) && !imem_ready;

  assign PC_D       = pc_fd_q;
  assign Instr_D    = instr_fd_q;
  assign PC_plus4_D = pc4_fd_q;
  assign valid_D    = valid_fd_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_d, perf_fetched_q;
  logic [31:0] perf_miss_d, perf_miss_q;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_miss_d    = perf_miss_q;
    if (fd_load && valid_fd_d && !flush_D && !redirect)
      perf_fetched_d = perf_fetched_q + 32'd1;
    if (fetch_busy)
      perf_miss_d = perf_miss_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_fetched_q <= '0;
      perf_miss_q    <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_miss_q    <= perf_miss_d;
    end
  end

  assign perf_fetched     = perf_fetched_q;
  assign perf_miss_cycles = perf_miss_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module : tb_fetch_stage
// Brief  : Directed self-checking bench for fetch_stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        CLK;
  logic        RST;
  logic        stall_D;
  logic        flush_D;
  logic        redirect;
  logic [31:0] redirect_PC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PC_D;
  logic [31:0] Instr_D;
  logic [31:0] PC_plus4_D;
  logic        valid_D;
  logic        fetch_busy;

  int errors = 0;
  int checks = 0;

  // Memory returns a recognisable word derived from the requested address.
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .stall_D     (stall_D),
    .flush_D     (flush_D),
    .redirect    (redirect),
    .redirect_PC (redirect_PC),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .PC_D        (PC_D),
    .Instr_D     (Instr_D),
    .PC_plus4_D  (PC_plus4_D),
    .valid_D     (valid_D),
    .fetch_busy  (fetch_busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; stall_D = 1'b0; flush_D = 1'b0; redirect = 1'b0;
    redirect_PC = '0; imem_ready = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; stall_D = 1'b0; flush_D = 1'b0; redirect = 1'b0;
    redirect_PC = '0; imem_ready = 1'b0;
    #2;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (valid_D !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_D); end
    checks++; if (PC_D !== 32'h0) begin errors++; $display("FAIL reset_pcd: got %h want 0", PC_D); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    imem_ready = 1'b1;
    tick();
    checks++; if (PC_D !== 32'h0 || valid_D !== 1'b1) begin errors++; $display("FAIL hit0: got pc=%h v=%b want 0/1", PC_D, valid_D); end
    checks++; if (Instr_D !== 32'hC0DE_0000 || PC_plus4_D !== 32'h4) begin errors++; $display("FAIL hit0_data: got %h/%h want c0de0000/4", Instr_D, PC_plus4_D); end
    tick();
    checks++; if (PC_D !== 32'h4 || valid_D !== 1'b1) begin errors++; $display("FAIL hit4: got pc=%h v=%b want 4/1", PC_D, valid_D); end
    tick();
    checks++; if (PC_D !== 32'h8 || valid_D !== 1'b1) begin errors++; $display("FAIL hit8: got pc=%h v=%b want 8/1", PC_D, valid_D); end
  endtask

  task automatic test_miss();
    do_reset();
    imem_ready = 1'b1;
    tick();
    tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (imem_addr !== 32'h8 || fetch_busy !== 1'b1) begin errors++; $display("FAIL miss_cyc%0d: got addr=%h busy=%b want 8/1", i, imem_addr, fetch_busy); end
      tick();
      checks++; if (valid_D !== 1'b0) begin errors++; $display("FAIL miss_bubble%0d: got %b want 0", i, valid_D); end
    end
    imem_ready = 1'b1;
    #1;
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL miss_busy_end: got %b want 0", fetch_busy); end
    tick();
    checks++; if (PC_D !== 32'h8 || Instr_D !== 32'hC0DE_0008 || valid_D !== 1'b1) begin errors++; $display("FAIL miss_deliver: got %h/%h/%b want 8/c0de0008/1", PC_D, Instr_D, valid_D); end
  endtask

  task automatic test_stall();
    do_reset();
    imem_ready = 1'b1;
    tick(); tick(); tick();
    stall_D = 1'b1;
    #1;
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL stall_addr: got %h want c", imem_addr); end
    tick();
    checks++; if (PC_D !== 32'h8 || valid_D !== 1'b1) begin errors++; $display("FAIL stall_hold1: got %h/%b want 8/1", PC_D, valid_D); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req: got %b want 0", imem_req); end
    tick();
    checks++; if (PC_D !== 32'h8 || valid_D !== 1'b1) begin errors++; $display("FAIL stall_hold2: got %h/%b want 8/1", PC_D, valid_D); end
    stall_D = 1'b0;
    tick();
    checks++; if (PC_D !== 32'hC || Instr_D !== 32'hC0DE_000C || valid_D !== 1'b1) begin errors++; $display("FAIL hold_release: got %h/%h/%b want c/c0de000c/1", PC_D, Instr_D, valid_D); end
    tick();
    checks++; if (PC_D !== 32'h10 || valid_D !== 1'b1) begin errors++; $display("FAIL after_hold: got %h/%b want 10/1", PC_D, valid_D); end
  endtask

  task automatic test_redirect_miss();
    do_reset();
    imem_ready = 1'b1;
    tick(); tick();
    imem_ready = 1'b0;
    tick();
    redirect = 1'b1; redirect_PC = 32'h100;
    tick();
    redirect = 1'b0;
    checks++; if (valid_D !== 1'b0 || PC_D !== 32'h0) begin errors++; $display("FAIL redir_flush: got %h/%b want 0/0", PC_D, valid_D); end
    #1;
    checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1 || fetch_busy !== 1'b1) begin errors++; $display("FAIL drop_req: got addr=%h req=%b busy=%b want 8/1/1", imem_addr, imem_req, fetch_busy); end
    imem_ready = 1'b1;
    tick();
    checks++; if (valid_D !== 1'b0) begin errors++; $display("FAIL drop_discard: got %b want 0", valid_D); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL drop_target: got %h want 100", imem_addr); end
    tick();
    checks++; if (PC_D !== 32'h100 || Instr_D !== 32'hC0DE_0100 || valid_D !== 1'b1) begin errors++; $display("FAIL redir_deliver: got %h/%h/%b want 100/c0de0100/1", PC_D, Instr_D, valid_D); end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_ready = 1'b1;
    redirect = 1'b1; redirect_PC = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL align_addr: got %h want fffffffc", imem_addr); end
    tick();
    checks++; if (PC_D !== 32'hFFFF_FFFC || PC_plus4_D !== 32'h0) begin errors++; $display("FAIL wrap_fd: got %h/%h want fffffffc/0", PC_D, PC_plus4_D); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_flush_stall();
    do_reset();
    imem_ready = 1'b1;
    tick(); tick();
    stall_D = 1'b1; flush_D = 1'b1;
    tick();
    checks++; if (valid_D !== 1'b0 || Instr_D !== 32'h0 || PC_D !== 32'h0) begin errors++; $display("FAIL flush_stall: got %h/%h/%b want 0/0/0", PC_D, Instr_D, valid_D); end
    stall_D = 1'b0; flush_D = 1'b0;
    tick();
    checks++; if (PC_D !== 32'h8 || valid_D !== 1'b1) begin errors++; $display("FAIL flush_resume: got %h/%b want 8/1", PC_D, valid_D); end
  endtask

  task automatic test_async_reset();
    do_reset();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick();
    #2;
    RST = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("FAIL async_req: got req=%b busy=%b want 0/0", imem_req, fetch_busy); end
    checks++; if (PC_D !== 32'h0 || valid_D !== 1'b0) begin errors++; $display("FAIL async_fd: got %h/%b want 0/0", PC_D, valid_D); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL restart: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    imem_ready = 1'b1;
    tick();
    checks++; if (PC_D !== 32'h0 || valid_D !== 1'b1) begin errors++; $display("FAIL restart_fd: got %h/%b want 0/1", PC_D, valid_D); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_miss();
    test_stall();
    test_redirect_miss();
    test_wrap();
    test_flush_stall();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port stall_D, input, 1 bit: decode cannot accept; the F/D outputs hold.
REQ-005 The block SHALL have port flush_D, input, 1 bit: kill the F/D contents.
REQ-006 The block SHALL have port redirect, input, 1 bit: taken branch or jump resolved in execute.
REQ-007 The block SHALL have port redirect_PC, input, 32 bits: the target PC for redirect.
REQ-008 The block SHALL have ports imem_req (output, 1 bit) and imem_addr (output, 32 bits): the instruction memory/cache request.
REQ-009 The block SHALL have ports imem_ready (input, 1 bit) and imem_rdata (input, 32 bits): the response; data is valid in a cycle where imem_ready=1.
REQ-010 The block SHALL have ports PC_D, Instr_D and PC_plus4_D (outputs, 32 bits each) and valid_D (output, 1 bit): the F/D register.
REQ-011 The block SHALL have port fetch_busy, output, 1 bit: a miss is in progress, for the hazard unit.

Function
REQ-012 The block SHALL have states FETCH, HOLD and DROP.
REQ-013 Memory handshake: while imem_req=1, imem_addr SHALL stay stable until imem_ready=1.
REQ-014 Memory handshake: a ready in the same cycle as the request (zero-wait hit) SHALL be legal.
REQ-015 FETCH: imem_req=1 and imem_addr=PC.
REQ-016 FETCH, on imem_ready with stall_D=0: the F/D register SHALL load {PC, imem_rdata, PC+4, valid=1}, and PC SHALL become PC+4.
REQ-017 FETCH, on imem_ready with stall_D=1: the instruction SHALL be captured in the hold buffer and the state SHALL go to HOLD.
REQ-018 HOLD: imem_req=0; when stall_D=0, the hold buffer SHALL load into F/D, PC SHALL become PC+4, and the state SHALL go to FETCH.
REQ-019 Redirect has highest priority: PC SHALL become redirect_PC, and the hold buffer and any returning data SHALL be discarded.
REQ-020 Redirect while a request is outstanding and imem_ready=0: the state SHALL go to DROP.
REQ-021 Redirect in any other case: the state SHALL go to FETCH.
REQ-022 DROP: the old request SHALL stay asserted with its original address; on imem_ready the data SHALL be discarded and the state SHALL go to FETCH, fetching the redirect target.
REQ-023 A redirect SHALL also clear F/D exactly as flush_D does.
REQ-024 flush_D (or redirect) SHALL zero PC_D, Instr_D, PC_plus4_D and valid_D on the next edge, overriding stall_D.
REQ-025 While stall_D=1 and there is no flush, the F/D outputs SHALL hold their values.
REQ-026 When FETCH receives no imem_ready, valid_D SHALL become 0 next cycle (a bubble) unless stall_D=1.
REQ-027 fetch_busy SHALL be 1 in FETCH or DROP while imem_ready=0, and 0 otherwise.
REQ-028 PC+4 SHALL be computed modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-029 PC[1:0] SHALL be ignored and always driven 0 on imem_addr.
REQ-030 Fetch-to-F/D latency SHALL be 1 cycle after imem_ready.

Reset
REQ-031 Asserting RST SHALL immediately set PC=RESET_PC and state=FETCH, and clear the hold buffer and all F/D outputs.
REQ-032 While RST=1, imem_req SHALL be 0.
REQ-033 A request in flight when RST asserts SHALL be abandoned; the memory SHALL tolerate this.
REQ-034 The first request SHALL be issued in the first cycle after RST deasserts.

Configuration
REQ-035 With macro FETCH_PERF_CNT_EN defined, the block SHALL add outputs perf_fetched (32 bits, count of instructions delivered to F/D with valid=1) and perf_miss_cycles (32 bits, count of cycles with fetch_busy=1).
REQ-036 The perf counters SHALL be reset to 0 and SHALL wrap.
REQ-037 Without FETCH_PERF_CNT_EN, those ports and counters SHALL not exist and behaviour SHALL otherwise be identical.

Structure
REQ-038 A shared package fetch_pkg SHALL hold the state enum fetch_state_t and the localparams INSTR_W=32 and PC_STEP=4.
REQ-039 The hold buffer (PC and instruction with a valid bit, load/clear controls) SHALL be a sub-module, fetch_hold_buf.

Verification
REQ-040 Zero-wait hits from RESET_PC=0: imem_ready held at 1 SHALL give PC_D=0,4,8 on consecutive cycles with valid_D=1.
REQ-041 Miss: imem_ready low for 3 cycles at PC=8 SHALL give imem_addr=8 stable, fetch_busy=1 for 3 cycles, then Instr_D=imem_rdata and PC_D=8.
REQ-042 Stall: stall_D=1 for 2 cycles while an instruction returns at PC=12 SHALL hold F/D, enter HOLD, then deliver PC_D=12 with no duplicate or loss.
REQ-043 Redirect during a miss: redirect with redirect_PC=0x100 while waiting SHALL enter DROP, discard the late data, then fetch 0x100 with valid_D=0 in between.
REQ-044 flush_D with stall_D=1 together SHALL give valid_D=0 and Instr_D=0 next cycle; async RST mid-miss SHALL give imem_req=0 immediately and PC restarting at RESET_PC.
